// File: rtl/wb_align_stage_if.sv
// Writeback-stage bus: retiring instruction from MEM, load data return,
// and the register-file write port produced by the stage.
interface wb_align_stage_if #(
  parameter int OP_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [4:0]      in_rd;
  logic [31:0]     in_alu_result;
  logic [1:0]      in_addr_lo;
  logic [31:0]     mem_rdata;
  logic            mem_rdata_valid;
  logic [4:0]      Rd_addr;
  logic [31:0]     Rd_in;
  logic [3:0]      Rd_Byte_w_en;
  logic            misalign_err;

  modport master (
    output in_valid, in_op, in_rd, in_alu_result, in_addr_lo, mem_rdata, mem_rdata_valid,
    input  in_ready, Rd_addr, Rd_in, Rd_Byte_w_en, misalign_err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_alu_result, in_addr_lo, mem_rdata, mem_rdata_valid,
    output in_ready, Rd_addr, Rd_in, Rd_Byte_w_en, misalign_err
  );
endinterface

// File: rtl/wb_align_stage.sv
// MIPS writeback stage: waits for load data, aligns it and emits a registered
// register-file write with per-byte enables (LWL/LWR merge via enables only).
module wb_align_stage #(
  parameter int OP_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  wb_align_stage_if.slave bus
);

  localparam logic [OP_W-1:0] OP_ALU = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LWL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_LWR = OP_W'(7);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_WRITE     = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      addr_q, addr_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic [3:0]      wr_en_q, wr_en_d;
  logic            err_q, err_d;

  logic            accept;
  logic [31:0]     shr_data;
  logic [31:0]     shl_data;
  logic [15:0]     half;
  logic [31:0]     load_data;
  logic [3:0]      load_en;
  logic            load_err;

  assign bus.in_ready     = (state_q != ST_LOAD_WAIT);
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.Rd_addr      = wr_addr_q;
  assign bus.Rd_in        = wr_data_q;
  assign bus.Rd_Byte_w_en = wr_en_q;
  assign bus.misalign_err = err_q;

  // 3-a equals ~a for a two-bit offset.
  assign shr_data = bus.mem_rdata >> {addr_q, 3'b000};
  assign shl_data = bus.mem_rdata << {~addr_q, 3'b000};
  assign half     = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    load_data = bus.mem_rdata;
    load_en   = 4'b1111;
    load_err  = 1'b0;
    case (op_q)
      OP_LB:  load_data = {{24{shr_data[7]}}, shr_data[7:0]};
      OP_LBU: load_data = {24'b0, shr_data[7:0]};
      OP_LH, OP_LHU: begin
        load_data = (op_q == OP_LH) ? {{16{half[15]}}, half} : {16'b0, half};
        if (addr_q[0]) begin
          load_en  = 4'b0000;
          load_err = 1'b1;
        end
      end
      OP_LW: begin
        if (addr_q != 2'b00) begin
          load_en  = 4'b0000;
          load_err = 1'b1;
        end
      end
      OP_LWL: begin
        load_data = shl_data;
        load_en   = 4'b1111 << ~addr_q;
      end
      OP_LWR: begin
        load_data = shr_data;
        load_en   = 4'b1111 >> addr_q;
      end
      default: ;
    endcase
    // r0 is never written, but a misaligned access still reports.
    if (rd_q == 5'd0) load_en = 4'b0000;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 4'b0000;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (accept) begin
          if (bus.in_op == OP_ALU) begin
            state_d   = ST_WRITE;
            wr_addr_d = bus.in_rd;
            wr_data_d = bus.in_alu_result;
            wr_en_d   = (bus.in_rd != 5'd0) ? 4'b1111 : 4'b0000;
          end else begin
            state_d = ST_LOAD_WAIT;
            op_d    = bus.in_op;
            rd_d    = bus.in_rd;
            addr_d  = bus.in_addr_lo;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_WAIT: begin
        if (bus.mem_rdata_valid) begin
          state_d   = ST_WRITE;
          wr_addr_d = rd_q;
          wr_data_d = load_data;
          wr_en_d   = load_en;
          err_d     = load_err;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ALU;
      rd_q      <= 5'd0;
      addr_q    <= 2'd0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
      wr_en_q   <= 4'b0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
    end
  end

endmodule
